axi_stream_master: RTL and testbench
====================================

Name: axi_stream_master

Overview:
AXI-Stream transmitter. It is the other end of the team's stream slave: it takes beats from an internal producer over a valid/ready handshake and drives them onto an AXI-Stream bus. A 2-entry skid buffer decouples the producer from downstream backpressure. A beat counter generates tlast from a per-packet beat count. It sits at the output of the MAC/auth datapath and feeds the stream slave on the far side.

Parameters:
TDATA_WIDTH, 512, data bus width in bits, multiple of 8
TID_WIDTH, 8, tid width
TDEST_WIDTH, 8, tdest width
TUSER_WIDTH, 8, tuser width
MAX_BEATS, 16, maximum beats per packet, >=1; CNT_W = $clog2(MAX_BEATS+1)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-high
in_valid  in  1  producer beat valid
in_data  in  TDATA_WIDTH  producer beat data
in_id  in  TID_WIDTH  sideband, captured with the beat
in_dest  in  TDEST_WIDTH  sideband, captured with the beat
in_user  in  TUSER_WIDTH  sideband, captured with the beat
in_ready  out  1  buffer can accept a beat
cfg_pkt_beats  in  CNT_W  beats per packet; 0 is treated as 1
pkt_done  out  1  one-cycle pulse on the handshake of a tlast beat
tvalid  out  1  AXI valid
tdata  out  TDATA_WIDTH  AXI data
tstrb  out  TDATA_WIDTH/8  constant all ones
tkeep  out  TDATA_WIDTH/8  constant all ones
tlast  out  1  last beat of the packet
tid  out  TID_WIDTH  AXI id
tdest  out  TDEST_WIDTH  AXI dest
tuser  out  TUSER_WIDTH  AXI user
twakeup  out  1  high when buffer non-empty or in_valid=1
tready  in  1  AXI ready

Behaviour:
- Clock is aclk. Reset is aresetn, asynchronous, active-high.
- While aresetn=1:
  - buffer is emptied; occupancy=0; beat_cnt=0
  - tvalid=0, in_ready=0, pkt_done=0, tlast=0, twakeup=0
  - tdata/tid/tdest/tuser=0
- The first rising aclk after reset release sets in_ready=1.
- Push: in_valid & in_ready at rising edge. Pop: tvalid & tready at rising edge.
- Buffer: 2 entries, circular head/tail pointers, each entry holds {data, id, dest, user}. All AXI payload outputs come straight from the head-entry register; no combinational path from in_* to t*.
- Occupancy 0→1 on push only; 1→1 on push+pop; 1→0 on pop only; 1→2 on push only; 2→1 on pop.
- in_ready = (occupancy<2). It is registered and updated on the same edge as occupancy, so no in_ready→tready combinational path exists.
- A push while full cannot occur, because in_ready=0.
- tvalid = (occupancy>0).
- Latency: a push at edge N gives tvalid=1 with that beat after edge N. Sustained rate is 1 beat/cycle when tready is held high.
- AXI rules:
  - Once tvalid=1, tvalid and all payload outputs (including tlast) stay stable until the pop.
  - tvalid never depends on tready.
- tlast generation:
  - eff_len = (beat_cnt==0) ? max(cfg_pkt_beats,1) : latched_len.
  - On a pop with beat_cnt==0, latched_len <= max(cfg_pkt_beats,1).
  - tlast = tvalid & (beat_cnt == eff_len-1).
  - On a pop: if tlast, beat_cnt <= 0 and pkt_done=1 for the next cycle; otherwise beat_cnt++.
  - cfg_pkt_beats must be stable while beat_cnt==0 and tvalid=1. Mid-packet changes to cfg_pkt_beats take effect from the next packet.
- cfg_pkt_beats > MAX_BEATS is clamped to MAX_BEATS.
- twakeup = tvalid | in_valid (combinational).
- Reset mid-packet: buffer contents are dropped, beat_cnt=0, and the next beat starts a new packet.

Decomposition:
- Package axis_pkg: TDATA_WIDTH/TID_WIDTH/TDEST_WIDTH/TUSER_WIDTH defaults, and typedef axis_beat_t struct {data, id, dest, user}, shared with the stream slave.
- Sub-module axis_skid_buf: the 2-entry buffer with push/pop/occupancy and in_ready/tvalid.
- Top level: the beat counter, tlast/pkt_done logic, and constant tstrb/tkeep.

Test Plan:
1. Reset check: hold aresetn=1 with in_valid=1 → tvalid=0, in_ready=0, tlast=0. Release reset → in_ready=1 after the first edge.
2. Streaming: cfg_pkt_beats=4, tready=1, push 8 beats data=0..7 back-to-back → tvalid continuous from the cycle after the first push; tlast on data 3 and 7; pkt_done pulses twice.
3. Backpressure: tready=0, push 3 beats A,B,C → A and B accepted; in_ready=0 on C; tdata=A held stable. Raise tready → A, B, C emitted in order with no loss or duplication.
4. Single-beat packets: cfg_pkt_beats=0 then 1, push 3 beats → tlast=1 on every beat.
5. Random tready (50%) with a random in_valid over 1000 beats, cfg_pkt_beats=5:
   - scoreboard shows output = input order
   - tlast on every 5th beat
   - payload stable while tvalid & ~tready
6. Reset mid-packet: cfg=4, after 2 beats sent, assert aresetn for 1 cycle → tvalid drops immediately, and the next packet's 4th beat carries tlast.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the stream master / stream slave pair.
package axis_pkg;

  localparam int AXIS_TDATA_W = 512;
  localparam int AXIS_TID_W   = 8;
  localparam int AXIS_TDEST_W = 8;
  localparam int AXIS_TUSER_W = 8;

  typedef struct packed {
    logic [AXIS_TDATA_W-1:0] data;
    logic [AXIS_TID_W-1:0]   id;
    logic [AXIS_TDEST_W-1:0] dest;
    logic [AXIS_TUSER_W-1:0] user;
  } axis_beat_t;

  // Packet length actually used: 0 means 1, anything above max_beats saturates.
  function automatic int axis_pkt_len(input int cfg, input int max_beats);
    if (cfg < 1) return 1;
    if (cfg > max_beats) return max_beats;
    return cfg;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry circular buffer between the producer handshake and the AXI bus.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data,
  input  logic         pop_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_occ;
  logic         r_ready;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_occ_next;

  assign w_push = push_valid & r_ready;
  assign w_pop  = (r_occ != 2'd0) & pop_ready;

  always_comb begin
    w_occ_next = r_occ;
    if (w_push & ~w_pop)
      w_occ_next = r_occ + 2'd1;
    else if (w_pop & ~w_push)
      w_occ_next = r_occ - 2'd1;
  end

  // Ready is registered from the next occupancy so tready never reaches in_ready.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_occ    <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop)
        r_head <= ~r_head;
      r_occ   <= w_occ_next;
      r_ready <= (w_occ_next != 2'd2);
    end
  end

  assign push_ready = r_ready;
  assign pop_valid  = (r_occ != 2'd0);
  assign pop_data   = r_mem[r_head];

endmodule

// File: rtl/axi_stream_master.sv
// AXI-Stream transmitter: skid-buffered producer beats with tlast generated
// from a per-packet beat count.
module axi_stream_master
  import axis_pkg::*;
#(
  parameter  int TDATA_WIDTH = AXIS_TDATA_W,
  parameter  int TID_WIDTH   = AXIS_TID_W,
  parameter  int TDEST_WIDTH = AXIS_TDEST_W,
  parameter  int TUSER_WIDTH = AXIS_TUSER_W,
  parameter  int MAX_BEATS   = 16,
  localparam int CNT_W       = $clog2(MAX_BEATS + 1)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     in_valid,
  input  logic [TDATA_WIDTH-1:0]   in_data,
  input  logic [TID_WIDTH-1:0]     in_id,
  input  logic [TDEST_WIDTH-1:0]   in_dest,
  input  logic [TUSER_WIDTH-1:0]   in_user,
  output logic                     in_ready,
  input  logic [CNT_W-1:0]         cfg_pkt_beats,
  output logic                     pkt_done,
  output logic                     tvalid,
  output logic [TDATA_WIDTH-1:0]   tdata,
  output logic [TDATA_WIDTH/8-1:0] tstrb,
  output logic [TDATA_WIDTH/8-1:0] tkeep,
  output logic                     tlast,
  output logic [TID_WIDTH-1:0]     tid,
  output logic [TDEST_WIDTH-1:0]   tdest,
  output logic [TUSER_WIDTH-1:0]   tuser,
  output logic                     twakeup,
  input  logic                     tready
);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
    logic [TUSER_WIDTH-1:0] user;
  } beat_t;

  beat_t            w_in_beat;
  beat_t            w_out_beat;
  logic             w_tvalid;
  logic             w_pop;
  logic             w_tlast;
  logic [CNT_W-1:0] w_cfg_len;
  logic [CNT_W-1:0] w_eff_len;

  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_latched_len;
  logic             r_pkt_done;

  assign w_in_beat = '{data: in_data, id: in_id, dest: in_dest, user: in_user};

  axis_skid_buf #(
    .W($bits(beat_t))
  ) u_buf (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push_valid (in_valid),
    .push_data  (w_in_beat),
    .push_ready (in_ready),
    .pop_valid  (w_tvalid),
    .pop_data   (w_out_beat),
    .pop_ready  (tready)
  );

  // The length is taken live for a packet's first beat and held for the rest.
  assign w_cfg_len = CNT_W'(axis_pkt_len(int'(cfg_pkt_beats), MAX_BEATS));
  assign w_eff_len = (r_beat_cnt == '0) ? w_cfg_len : r_latched_len;
  assign w_tlast   = w_tvalid & (r_beat_cnt == (w_eff_len - CNT_W'(1)));
  assign w_pop     = w_tvalid & tready;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_beat_cnt    <= '0;
      r_latched_len <= '0;
      r_pkt_done    <= 1'b0;
    end else begin
      r_pkt_done <= w_pop & w_tlast;
      if (w_pop) begin
        if (r_beat_cnt == '0)
          r_latched_len <= w_cfg_len;
        if (w_tlast)
          r_beat_cnt <= '0;
        else
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign tvalid   = w_tvalid;
  assign tdata    = w_out_beat.data;
  assign tid      = w_out_beat.id;
  assign tdest    = w_out_beat.dest;
  assign tuser    = w_out_beat.user;
  assign tlast    = w_tlast;
  assign tstrb    = '1;
  assign tkeep    = '1;
  assign pkt_done = r_pkt_done;
  assign twakeup  = ~aresetn & (w_tvalid | in_valid);

endmodule

// File: tb/tb_axi_stream_master.sv
// Scoreboarded random/directed bench for axi_stream_master.
module tb_axi_stream_master;

  localparam int DW   = 64;
  localparam int IW   = 8;
  localparam int DSW  = 8;
  localparam int UW   = 8;
  localparam int MAXB = 16;
  localparam int CW   = 5;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
    logic           last;
  } exp_t;

  logic            aclk;
  logic            aresetn;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [IW-1:0]   in_id;
  logic [DSW-1:0]  in_dest;
  logic [UW-1:0]   in_user;
  logic            in_ready;
  logic [CW-1:0]   cfg_pkt_beats;
  logic            pkt_done;
  logic            tvalid;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic [IW-1:0]   tid;
  logic [DSW-1:0]  tdest;
  logic [UW-1:0]   tuser;
  logic            twakeup;
  logic            tready;

  axi_stream_master #(
    .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW), .TUSER_WIDTH(UW), .MAX_BEATS(MAXB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .in_valid(in_valid), .in_data(in_data),
    .in_id(in_id), .in_dest(in_dest), .in_user(in_user), .in_ready(in_ready),
    .cfg_pkt_beats(cfg_pkt_beats), .pkt_done(pkt_done), .tvalid(tvalid),
    .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid),
    .tdest(tdest), .tuser(tuser), .twakeup(twakeup), .tready(tready)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  int   m_pos = 0;
  int   rel_edges = 0;
  bit   exp_done = 0;
  bit   prev_stall = 0;
  exp_t prev_out;
  bit   rand_tready = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_len(input int c);
    if (c == 0) return 1;
    if (c > MAXB) return MAXB;
    return c;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Edges seen since reset release; in_ready may only rise after the first one.
  always @(posedge aclk) begin
    if (aresetn) rel_edges = 0;
    else if (rel_edges < 4) rel_edges = rel_edges + 1;
  end

  always @(posedge aclk) begin
    if (rand_tready) begin
      #1;
      tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: observed state first, then the handshakes of the coming edge.
  always @(negedge aclk) begin
    exp_t act;
    exp_t e;
    int   len;
    act = {tdata, tid, tdest, tuser, tlast};
    if (aresetn) begin
      check("rst_tvalid", tvalid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_tlast", tlast, 1'b0);
      check("rst_pkt_done", pkt_done, 1'b0);
      check("rst_twakeup", twakeup, 1'b0);
      check("rst_payload", {tdata, tid, tdest, tuser}, '0);
      sb_q.delete();
      m_pos = 0;
      exp_done = 0;
      prev_stall = 0;
    end else begin
      check("pkt_done", pkt_done, exp_done);
      exp_done = 0;
      check("tvalid", tvalid, sb_q.size() != 0);
      check("in_ready", in_ready, (rel_edges >= 1) && (sb_q.size() < 2));
      check("twakeup", twakeup, (sb_q.size() != 0) || in_valid);
      check("tstrb_tkeep", {tstrb, tkeep}, {(DW/4){1'b1}});
      if (prev_stall) check("stable", act, prev_out);
      if (tvalid && tready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL beat_unexpected: got %0h expected no beat", act);
        end else begin
          e = sb_q.pop_front();
          check("beat", act, e);
          $display("beat out data=%0h last=%0b", tdata, tlast);
          if (e.last) exp_done = 1;
        end
      end
      prev_stall = tvalid && !tready;
      prev_out = act;
      if (in_valid && in_ready) begin
        len = ref_len(int'(cfg_pkt_beats));
        e = {in_data, in_id, in_dest, in_user, (m_pos == len - 1)};
        m_pos = e.last ? 0 : m_pos + 1;
        sb_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int waited = 0;
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_id    = IW'($urandom);
    in_dest  = DSW'($urandom);
    in_user  = UW'($urandom);
    while (!acc) begin
      @(negedge aclk);
      acc = in_ready;
      @(posedge aclk);
      #1;
      waited++;
      if (!acc && waited > 200) begin
        n_checks++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(posedge aclk);
      #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sb_q.size());
    end
    idle(3);
  endtask

  initial begin
    aresetn = 1'b1;
    in_valid = 1'b1;
    in_data = '1;
    in_id = '0;
    in_dest = '0;
    in_user = '0;
    tready = 1'b0;
    cfg_pkt_beats = CW'(4);
    repeat (3) @(posedge aclk);
    #1;
    in_valid = 1'b0;
    aresetn = 1'b0;
    check("in_ready_before_edge", in_ready, 1'b0);
    @(posedge aclk);
    #1;
    check("in_ready_after_release", in_ready, 1'b1);

    // Back-to-back streaming, 4-beat packets.
    tready = 1'b1;
    for (int i = 0; i < 8; i++) send(DW'(i));
    drain();

    // Backpressure: third beat must wait for tready.
    cfg_pkt_beats = CW'(3);
    tready = 1'b0;
    send(DW'(64'hA));
    send(DW'(64'hB));
    check("full_in_ready", in_ready, 1'b0);
    fork
      send(DW'(64'hC));
      begin
        repeat (4) @(posedge aclk);
        #1;
        tready = 1'b1;
      end
    join
    drain();

    // Single-beat packets, then an oversized count that saturates.
    cfg_pkt_beats = CW'(0);
    for (int i = 0; i < 3; i++) send(DW'(100 + i));
    drain();
    cfg_pkt_beats = CW'(1);
    for (int i = 0; i < 3; i++) send(DW'(200 + i));
    drain();
    cfg_pkt_beats = CW'(31);
    for (int i = 0; i < 32; i++) send(DW'(300 + i));
    drain();

    // Random traffic and backpressure, 5-beat packets.
    cfg_pkt_beats = CW'(5);
    rand_tready = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send({$urandom, $urandom});
    end
    drain();
    rand_tready = 0;
    idle(2);
    tready = 1'b1;

    // Reset in the middle of a packet.
    cfg_pkt_beats = CW'(4);
    send(DW'(64'h51));
    send(DW'(64'h52));
    drain();
    tready = 1'b0;
    send(DW'(64'h53));
    check("pre_reset_tvalid", tvalid, 1'b1);
    aresetn = 1'b1;
    #1;
    check("async_reset_tvalid", tvalid, 1'b0);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 4; i++) send(DW'(64'h60 + i));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
